// File: rtl/task_sequencer.sv
// Sequences one software-requested task: publishes the enabled-task mask, launches the task, counts its RX bytes and posts the results.
// Every register write is held until a cycle with REG_WR_BUSY low; RX_TREADY is only high while a task runs.
module task_sequencer #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          NUM_TASKS          = 4,
  parameter logic [31:0] TASK_EN_MASK       = 32'h0000_000F
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] CUR_TASK,
  input  logic                          TASK_IN_READY,
  input  logic                          PL_RST,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] NUM_BYTES_IN,
  input  logic                          TV_OUT_ACK,
  input  logic                          REG_WR_BUSY,
  output logic                          PL_READY,
  output logic                          PL_READY_WR_EN,
  output logic [C_S_AXI_DATA_WIDTH-1:0] EN_TASKS,
  output logic                          EN_TASKS_WR_EN,
  output logic                          TASK_OUT_READY,
  output logic                          TASK_OUT_READY_WR_EN,
  output logic [C_S_AXI_DATA_WIDTH-1:0] NUM_CAPT,
  output logic                          NUM_CAPT_WR_EN,
  output logic [4:0]                    TASK_ID,
  output logic [C_S_AXI_DATA_WIDTH-1:0] TASK_NBYTES,
  output logic                          TASK_START,
  input  logic                          TASK_DONE,
  input  logic [7:0]                    RX_TDATA,
  input  logic                          RX_TVALID,
  output logic                          RX_TREADY
);

  localparam int W = C_S_AXI_DATA_WIDTH;

  typedef enum logic [3:0] {
    INIT_EN, INIT_RDY, IDLE, START, RUN, POST_CNT, POST_RDY, WAIT_ACK, CLR_RDY
  } state_t;

  state_t         state_q, state_d;
  logic           pl_ready_q, pl_ready_d;
  logic           pl_ready_wr_en_q, pl_ready_wr_en_d;
  logic [W-1:0]   en_tasks_q, en_tasks_d;
  logic           en_tasks_wr_en_q, en_tasks_wr_en_d;
  logic           out_rdy_q, out_rdy_d;
  logic           out_rdy_wr_en_q, out_rdy_wr_en_d;
  logic [W-1:0]   num_capt_q, num_capt_d;
  logic           num_capt_wr_en_q, num_capt_wr_en_d;
  logic [4:0]     task_id_q, task_id_d;
  logic [W-1:0]   task_nbytes_q, task_nbytes_d;
  logic           task_start_q, task_start_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           rst_posted_q, rst_posted_d;
  logic           task_valid;
  logic           unused_rx;

  assign unused_rx  = ^RX_TDATA;
  assign task_valid = (CUR_TASK < W'(NUM_TASKS)) && TASK_EN_MASK[CUR_TASK[4:0]];

  always_comb begin
    state_d          = state_q;
    pl_ready_d       = pl_ready_q;
    pl_ready_wr_en_d = pl_ready_wr_en_q;
    en_tasks_d       = en_tasks_q;
    en_tasks_wr_en_d = en_tasks_wr_en_q;
    out_rdy_d        = out_rdy_q;
    out_rdy_wr_en_d  = out_rdy_wr_en_q;
    num_capt_d       = num_capt_q;
    num_capt_wr_en_d = num_capt_wr_en_q;
    task_id_d        = task_id_q;
    task_nbytes_d    = task_nbytes_q;
    task_start_d     = 1'b0;
    cnt_d            = cnt_q;
    rst_posted_d     = rst_posted_q;

    if (PL_RST && state_q != INIT_RDY) begin
      state_d          = INIT_RDY;
      pl_ready_wr_en_d = 1'b0;
      en_tasks_wr_en_d = 1'b0;
      out_rdy_wr_en_d  = 1'b0;
      num_capt_wr_en_d = 1'b0;
      rst_posted_d     = 1'b0;
    end else begin
      unique case (state_q)
        INIT_EN: begin
          if (!en_tasks_wr_en_q) begin
            en_tasks_wr_en_d = 1'b1;
            en_tasks_d       = W'(TASK_EN_MASK);
          end else if (!REG_WR_BUSY) begin
            en_tasks_wr_en_d = 1'b0;
            state_d          = INIT_RDY;
          end
        end
        INIT_RDY: begin
          if (PL_RST) begin
            // A pending "ready=1" post is dropped; a "ready=0" post runs to commit exactly once.
            if (pl_ready_wr_en_q) begin
              if (pl_ready_q) begin
                pl_ready_wr_en_d = 1'b0;
              end else if (!REG_WR_BUSY) begin
                pl_ready_wr_en_d = 1'b0;
                rst_posted_d     = 1'b1;
              end
            end else if (!rst_posted_q) begin
              pl_ready_wr_en_d = 1'b1;
              pl_ready_d       = 1'b0;
            end
          end else begin
            rst_posted_d = 1'b0;
            if (!pl_ready_wr_en_q) begin
              pl_ready_wr_en_d = 1'b1;
              pl_ready_d       = 1'b1;
            end else if (!REG_WR_BUSY) begin
              pl_ready_wr_en_d = 1'b0;
              if (pl_ready_q) state_d = IDLE;
            end
          end
        end
        IDLE: begin
          if (TASK_IN_READY) begin
            task_id_d     = CUR_TASK[4:0];
            task_nbytes_d = NUM_BYTES_IN;
            if (task_valid) begin
              cnt_d   = '0;
              state_d = START;
            end else begin
              cnt_d   = '1;
              state_d = POST_CNT;
            end
          end
        end
        START: begin
          task_start_d = 1'b1;
          state_d      = RUN;
        end
        RUN: begin
          if (RX_TVALID && cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (TASK_DONE) state_d = POST_CNT;
        end
        POST_CNT: begin
          if (!num_capt_wr_en_q) begin
            num_capt_wr_en_d = 1'b1;
            num_capt_d       = cnt_q;
          end else if (!REG_WR_BUSY) begin
            num_capt_wr_en_d = 1'b0;
            state_d          = POST_RDY;
          end
        end
        POST_RDY: begin
          if (!out_rdy_wr_en_q) begin
            out_rdy_wr_en_d = 1'b1;
            out_rdy_d       = 1'b1;
          end else if (!REG_WR_BUSY) begin
            out_rdy_wr_en_d = 1'b0;
            state_d         = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (TV_OUT_ACK) state_d = CLR_RDY;
        end
        CLR_RDY: begin
          if (!out_rdy_wr_en_q) begin
            out_rdy_wr_en_d = 1'b1;
            out_rdy_d       = 1'b0;
          end else if (!REG_WR_BUSY) begin
            out_rdy_wr_en_d = 1'b0;
            state_d         = IDLE;
          end
        end
        default: state_d = INIT_EN;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q          <= INIT_EN;
      pl_ready_q       <= 1'b0;
      pl_ready_wr_en_q <= 1'b0;
      en_tasks_q       <= '0;
      en_tasks_wr_en_q <= 1'b0;
      out_rdy_q        <= 1'b0;
      out_rdy_wr_en_q  <= 1'b0;
      num_capt_q       <= '0;
      num_capt_wr_en_q <= 1'b0;
      task_id_q        <= '0;
      task_nbytes_q    <= '0;
      task_start_q     <= 1'b0;
      cnt_q            <= '0;
      rst_posted_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      pl_ready_q       <= pl_ready_d;
      pl_ready_wr_en_q <= pl_ready_wr_en_d;
      en_tasks_q       <= en_tasks_d;
      en_tasks_wr_en_q <= en_tasks_wr_en_d;
      out_rdy_q        <= out_rdy_d;
      out_rdy_wr_en_q  <= out_rdy_wr_en_d;
      num_capt_q       <= num_capt_d;
      num_capt_wr_en_q <= num_capt_wr_en_d;
      task_id_q        <= task_id_d;
      task_nbytes_q    <= task_nbytes_d;
      task_start_q     <= task_start_d;
      cnt_q            <= cnt_d;
      rst_posted_q     <= rst_posted_d;
    end
  end

  assign PL_READY             = pl_ready_q;
  assign PL_READY_WR_EN       = pl_ready_wr_en_q;
  assign EN_TASKS             = en_tasks_q;
  assign EN_TASKS_WR_EN       = en_tasks_wr_en_q;
  assign TASK_OUT_READY       = out_rdy_q;
  assign TASK_OUT_READY_WR_EN = out_rdy_wr_en_q;
  assign NUM_CAPT             = num_capt_q;
  assign NUM_CAPT_WR_EN       = num_capt_wr_en_q;
  assign TASK_ID              = task_id_q;
  assign TASK_NBYTES          = task_nbytes_q;
  assign TASK_START           = task_start_q;
  assign RX_TREADY            = (state_q == RUN);

endmodule

// File: tb/tb_task_sequencer.sv
// Directed bench for task_sequencer: init posts, valid/invalid tasks, busy hold-off, soft reset and hard reset mid-post.
module tb_task_sequencer;

  logic        clk = 1'b0;
  logic        S_AXI_ARESET, TASK_IN_READY, PL_RST, TV_OUT_ACK, REG_WR_BUSY;
  logic        TASK_DONE, RX_TVALID;
  logic [31:0] CUR_TASK, NUM_BYTES_IN;
  logic [7:0]  RX_TDATA;
  logic        PL_READY, PL_READY_WR_EN, EN_TASKS_WR_EN, TASK_OUT_READY, TASK_OUT_READY_WR_EN;
  logic        NUM_CAPT_WR_EN, TASK_START, RX_TREADY;
  logic [31:0] EN_TASKS, NUM_CAPT, TASK_NBYTES;
  logic [4:0]  TASK_ID;

  int tests = 0;
  int fails = 0;
  int capt_commits = 0;
  int start_cnt = 0;
  logic [31:0] last_capt = '0;
  bit mon_on = 1'b0;

  task_sequencer dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(S_AXI_ARESET), .CUR_TASK(CUR_TASK),
    .TASK_IN_READY(TASK_IN_READY), .PL_RST(PL_RST), .NUM_BYTES_IN(NUM_BYTES_IN),
    .TV_OUT_ACK(TV_OUT_ACK), .REG_WR_BUSY(REG_WR_BUSY),
    .PL_READY(PL_READY), .PL_READY_WR_EN(PL_READY_WR_EN),
    .EN_TASKS(EN_TASKS), .EN_TASKS_WR_EN(EN_TASKS_WR_EN),
    .TASK_OUT_READY(TASK_OUT_READY), .TASK_OUT_READY_WR_EN(TASK_OUT_READY_WR_EN),
    .NUM_CAPT(NUM_CAPT), .NUM_CAPT_WR_EN(NUM_CAPT_WR_EN),
    .TASK_ID(TASK_ID), .TASK_NBYTES(TASK_NBYTES), .TASK_START(TASK_START),
    .TASK_DONE(TASK_DONE), .RX_TDATA(RX_TDATA), .RX_TVALID(RX_TVALID), .RX_TREADY(RX_TREADY)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: note a NUM_CAPT commit happening at this edge, then sample #1 after it.
  task automatic step();
    if (NUM_CAPT_WR_EN === 1'b1 && REG_WR_BUSY === 1'b0 && S_AXI_ARESET === 1'b0) begin
      capt_commits++;
      last_capt = NUM_CAPT;
    end
    @(posedge clk);
    #1;
    if (TASK_START === 1'b1) start_cnt++;
    if (mon_on)
      check1("wren_onehot", $onehot0({EN_TASKS_WR_EN, PL_READY_WR_EN,
                                       TASK_OUT_READY_WR_EN, NUM_CAPT_WR_EN}), 1'b1);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return EN_TASKS_WR_EN;
      1:       return PL_READY_WR_EN;
      2:       return TASK_OUT_READY_WR_EN;
      3:       return NUM_CAPT_WR_EN;
      default: return TASK_START;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic lvl, input string tag);
    int n = 0;
    while (sig(sel) !== lvl && n < 40) begin
      step();
      n++;
    end
    check1(tag, sig(sel), lvl);
  endtask

  task automatic launch(input logic [31:0] ct, input logic [31:0] nb);
    CUR_TASK = ct; NUM_BYTES_IN = nb; TASK_IN_READY = 1'b1;
    step();
    TASK_IN_READY = 1'b0;
    check32("launch_id", {27'd0, TASK_ID}, ct & 32'h1F);
    check32("launch_nbytes", TASK_NBYTES, nb);
    check1("launch_nostart_yet", TASK_START, 1'b0);
    step();
    check1("launch_start", TASK_START, 1'b1);
    check1("launch_tready", RX_TREADY, 1'b1);
  endtask

  task automatic beats_then_done(input int n);
    RX_TVALID = 1'b1;
    repeat (n) step();
    RX_TVALID = 1'b0;
    TASK_DONE = 1'b1;
    step();
    TASK_DONE = 1'b0;
  endtask

  task automatic finish_txn(input logic [31:0] exp, input int busy_cycles, input bit poke);
    int c0 = capt_commits;
    int s0;
    logic [4:0] id0;
    wait_for(3, 1'b1, "ncapt_wren");
    check32("ncapt_val", NUM_CAPT, exp);
    if (busy_cycles > 0) begin
      REG_WR_BUSY = 1'b1;
      repeat (busy_cycles) begin
        step();
        check1("ncapt_hold", NUM_CAPT_WR_EN, 1'b1);
        check32("ncapt_stable", NUM_CAPT, exp);
        check1("ordy_not_early", TASK_OUT_READY_WR_EN, 1'b0);
      end
      REG_WR_BUSY = 1'b0;
    end
    step();
    check1("ncapt_drop", NUM_CAPT_WR_EN, 1'b0);
    check32("ncapt_commit_cnt", capt_commits, c0 + 1);
    check32("ncapt_commit_val", last_capt, exp);
    wait_for(2, 1'b1, "ordy_wren");
    check1("ordy_val", TASK_OUT_READY, 1'b1);
    check32("ordy_after_capt", capt_commits, c0 + 1);
    step();
    check1("ordy_drop", TASK_OUT_READY_WR_EN, 1'b0);
    step();
    if (poke) begin
      s0 = start_cnt; id0 = TASK_ID;
      CUR_TASK = 32'd0; TASK_IN_READY = 1'b1;
      step();
      TASK_IN_READY = 1'b0;
      repeat (3) step();
      check32("waitack_no_start", start_cnt, s0);
      check32("waitack_id_kept", {27'd0, TASK_ID}, {27'd0, id0});
    end
    check1("waitack_quiet", TASK_OUT_READY_WR_EN, 1'b0);
    TV_OUT_ACK = 1'b1;
    step();
    TV_OUT_ACK = 1'b0;
    wait_for(2, 1'b1, "clr_wren");
    check1("clr_val", TASK_OUT_READY, 1'b0);
    step();
    check1("clr_drop", TASK_OUT_READY_WR_EN, 1'b0);
  endtask

  task automatic invalid_txn(input logic [31:0] ct);
    int s0 = start_cnt;
    CUR_TASK = ct; NUM_BYTES_IN = 32'd9; TASK_IN_READY = 1'b1;
    step();
    TASK_IN_READY = 1'b0;
    check32("inv_id", {27'd0, TASK_ID}, ct & 32'h1F);
    finish_txn(32'hFFFF_FFFF, 0, 1'b0);
    check32("inv_no_start", start_cnt, s0);
  endtask

  initial begin
    int s0, c0;
    S_AXI_ARESET = 1'b1; TASK_IN_READY = 1'b0; PL_RST = 1'b0; TV_OUT_ACK = 1'b0;
    REG_WR_BUSY = 1'b0; TASK_DONE = 1'b0; RX_TVALID = 1'b0; CUR_TASK = '0;
    NUM_BYTES_IN = '0; RX_TDATA = 8'hA5;
    repeat (3) step();
    mon_on = 1'b1;
    check1("rst_en_wren", EN_TASKS_WR_EN, 1'b0);
    check32("rst_en_tasks", EN_TASKS, 32'h0);
    check1("rst_pl_ready", PL_READY, 1'b0);
    check32("rst_num_capt", NUM_CAPT, 32'h0);
    check1("rst_tready", RX_TREADY, 1'b0);
    check1("rst_start", TASK_START, 1'b0);

    // Init sequence: EN_TASKS post, gap, PL_READY post.
    S_AXI_ARESET = 1'b0;
    step();
    check1("init_en_wren", EN_TASKS_WR_EN, 1'b1);
    check32("init_en_val", EN_TASKS, 32'h0000_000F);
    step();
    check1("init_en_drop", EN_TASKS_WR_EN, 1'b0);
    step();
    check1("init_rdy_wren", PL_READY_WR_EN, 1'b1);
    check1("init_rdy_val", PL_READY, 1'b1);
    step();
    check1("init_rdy_drop", PL_READY_WR_EN, 1'b0);

    // Task 2, five bytes.
    s0 = start_cnt;
    launch(32'd2, 32'd5);
    beats_then_done(5);
    check32("t2_one_start", start_cnt, s0 + 1);
    finish_txn(32'd5, 0, 1'b0);

    // Task 1, NUM_CAPT post stalled for three busy cycles.
    launch(32'd1, 32'd3);
    beats_then_done(3);
    finish_txn(32'd3, 3, 1'b0);

    // Unimplemented tasks: 7, first index past NUM_TASKS, and one aliasing task 1 in the low bits.
    invalid_txn(32'd7);
    invalid_txn(32'd4);
    invalid_txn(32'd33);

    // Soft reset in RUN after three beats.
    c0 = capt_commits;
    launch(32'd0, 32'd8);
    RX_TVALID = 1'b1;
    repeat (3) step();
    RX_TVALID = 1'b0;
    check1("plrst_tready_before", RX_TREADY, 1'b1);
    PL_RST = 1'b1;
    step();
    check1("plrst_tready_off", RX_TREADY, 1'b0);
    wait_for(1, 1'b1, "plrst_rdy0_wren");
    check1("plrst_rdy0_val", PL_READY, 1'b0);
    step();
    check1("plrst_rdy0_drop", PL_READY_WR_EN, 1'b0);
    repeat (4) step();
    check1("plrst_hold_quiet", PL_READY_WR_EN, 1'b0);
    check1("plrst_hold_val", PL_READY, 1'b0);
    PL_RST = 1'b0;
    wait_for(1, 1'b1, "plrst_rdy1_wren");
    check1("plrst_rdy1_val", PL_READY, 1'b1);
    step();
    check1("plrst_rdy1_drop", PL_READY_WR_EN, 1'b0);
    check32("plrst_no_capt", capt_commits, c0);

    // Task 3: done on the 4th beat, plus a stray start request while waiting for ack.
    s0 = start_cnt;
    launch(32'd3, 32'd4);
    RX_TVALID = 1'b1;
    repeat (3) step();
    TASK_DONE = 1'b1;
    step();
    TASK_DONE = 1'b0;
    RX_TVALID = 1'b0;
    finish_txn(32'd4, 0, 1'b1);
    check32("t3_one_start", start_cnt, s0 + 1);

    // Hard reset wins over soft reset and a stalled post.
    CUR_TASK = 32'd7; NUM_BYTES_IN = 32'd12; TASK_IN_READY = 1'b1;
    step();
    TASK_IN_READY = 1'b0;
    REG_WR_BUSY = 1'b1;
    wait_for(3, 1'b1, "hrst_pending_wren");
    S_AXI_ARESET = 1'b1; PL_RST = 1'b1;
    step();
    check1("hrst_capt_wren", NUM_CAPT_WR_EN, 1'b0);
    check32("hrst_num_capt", NUM_CAPT, 32'h0);
    check32("hrst_en_tasks", EN_TASKS, 32'h0);
    check1("hrst_pl_ready", PL_READY, 1'b0);
    check32("hrst_task_id", {27'd0, TASK_ID}, 32'h0);
    check32("hrst_nbytes", TASK_NBYTES, 32'h0);
    check1("hrst_pl_wren", PL_READY_WR_EN, 1'b0);
    S_AXI_ARESET = 1'b0; PL_RST = 1'b0; REG_WR_BUSY = 1'b0;
    step();
    check1("hrst_reinit_en", EN_TASKS_WR_EN, 1'b1);
    check32("hrst_reinit_val", EN_TASKS, 32'h0000_000F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
